// File: rtl/seg_scan_driver.sv
// Multiplexed N-digit seven-segment scan driver.
// Prescaled digit scan, hex decode, blanking, frame-aligned display update.
module seg_scan_driver #(
  parameter int NUM_DIGITS  = 8,
  parameter int REFRESH_DIV = 100000,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic                    Clk,
  input  logic                    Reset_n,
  input  logic [4*NUM_DIGITS-1:0] Value,
  input  logic [NUM_DIGITS-1:0]   DpIn,
  input  logic [NUM_DIGITS-1:0]   DigitEn,
  input  logic                    Load,
  input  logic                    LzBlank,
  output logic [6:0]              out7,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   en_out,
  output logic                    frame_done
);

  localparam int IW = $clog2(NUM_DIGITS);
  localparam int PW = $clog2(REFRESH_DIV);
  localparam int VW = 4 * NUM_DIGITS;
  localparam bit AL = (ACTIVE_LOW != 0);

  logic [PW-1:0]         presc_q, presc_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [VW-1:0]         sh_val_q, sh_val_d;
  logic [NUM_DIGITS-1:0] sh_dp_q, sh_dp_d;
  logic                  pend_q, pend_d;
  logic [VW-1:0]         dv_q, dv_d;
  logic [NUM_DIGITS-1:0] ddp_q, ddp_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [NUM_DIGITS-1:0] en_q, en_d;
  logic                  fd_q, fd_d;

  logic                  tick;
  logic                  bnd;
  logic [NUM_DIGITS-1:0] lzb;
  logic [3:0]            nib;
  logic                  lit;

  function automatic logic [6:0] dec7(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'b1111110;
      4'h1: s = 7'b0110000;
      4'h2: s = 7'b1101101;
      4'h3: s = 7'b1111001;
      4'h4: s = 7'b0110011;
      4'h5: s = 7'b1011011;
      4'h6: s = 7'b1011111;
      4'h7: s = 7'b1110000;
      4'h8: s = 7'b1111111;
      4'h9: s = 7'b1111011;
      4'hA: s = 7'b1110111;
      4'hB: s = 7'b0011111;
      4'hC: s = 7'b1001110;
      4'hD: s = 7'b0111101;
      4'hE: s = 7'b1001111;
      default: s = 7'b1000111;
    endcase
    return s;
  endfunction

  // Scan timing, shadow capture and frame-aligned display update
  always_comb begin
    tick     = (presc_q == PW'(REFRESH_DIV - 1));
    bnd      = tick && (idx_q == IW'(NUM_DIGITS - 1));
    presc_d  = tick ? '0 : presc_q + 1'b1;
    idx_d    = idx_q;
    if (tick) idx_d = bnd ? '0 : idx_q + 1'b1;
    fd_d     = bnd;
    sh_val_d = sh_val_q;
    sh_dp_d  = sh_dp_q;
    pend_d   = pend_q;
    dv_d     = dv_q;
    ddp_d    = ddp_q;
    if (Load) begin
      sh_val_d = Value;
      sh_dp_d  = DpIn;
      pend_d   = 1'b1;
    end
    if (bnd) begin
      if (Load) begin
        dv_d   = Value;
        ddp_d  = DpIn;
        pend_d = 1'b0;
      end else if (pend_q) begin
        dv_d   = sh_val_q;
        ddp_d  = sh_dp_q;
        pend_d = 1'b0;
      end
    end
  end

  // Leading-zero mask: walk down from the top digit while all zero, no DP
  always_comb begin
    logic za;
    za  = LzBlank;
    lzb = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      za     = za && (dv_q[4*k +: 4] == 4'h0) && !ddp_q[k];
      lzb[k] = (k != 0) && za;
    end
  end

  // Pin values for the current slot, polarity applied before registering
  always_comb begin
    nib  = dv_q[{idx_q, 2'b00} +: 4];
    lit  = DigitEn[idx_q] && !lzb[idx_q];
    seg_d = lit ? dec7(nib) : 7'b0;
    dp_d  = lit && ddp_q[idx_q];
    en_d  = '0;
    if (lit) en_d[idx_q] = 1'b1;
    seg_d = seg_d ^ {7{AL}};
    dp_d  = dp_d ^ AL;
    en_d  = en_d ^ {NUM_DIGITS{AL}};
  end

  // State and output registers
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      presc_q  <= '0;
      idx_q    <= '0;
      sh_val_q <= '0;
      sh_dp_q  <= '0;
      pend_q   <= 1'b0;
      dv_q     <= '0;
      ddp_q    <= '0;
      seg_q    <= {7{AL}};
      dp_q     <= AL;
      en_q     <= {NUM_DIGITS{AL}};
      fd_q     <= 1'b0;
    end else begin
      presc_q  <= presc_d;
      idx_q    <= idx_d;
      sh_val_q <= sh_val_d;
      sh_dp_q  <= sh_dp_d;
      pend_q   <= pend_d;
      dv_q     <= dv_d;
      ddp_q    <= ddp_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
      en_q     <= en_d;
      fd_q     <= fd_d;
    end
  end

  assign out7       = seg_q;
  assign dp_out     = dp_q;
  assign en_out     = en_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: cycle-indexed display model plus
// hand-computed pin checks, directed scenarios then random traffic.
module tb_seg_scan_driver;

  localparam int N   = 4;
  localparam int DIV = 4;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b1;
  logic [15:0] Value = '0;
  logic [3:0]  DpIn = '0;
  logic [3:0]  DigitEn = 4'hF;
  logic        Load = 1'b0;
  logic        LzBlank = 1'b0;
  logic [6:0]  out7;
  logic        dp_out;
  logic [3:0]  en_out;
  logic        frame_done;

  seg_scan_driver #(
    .NUM_DIGITS (N),
    .REFRESH_DIV(DIV),
    .ACTIVE_LOW (1)
  ) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .Value     (Value),
    .DpIn      (DpIn),
    .DigitEn   (DigitEn),
    .Load      (Load),
    .LzBlank   (LzBlank),
    .out7      (out7),
    .dp_out    (dp_out),
    .en_out    (en_out),
    .frame_done(frame_done)
  );

  always #5 Clk = ~Clk;

  int total = 0;
  int bad   = 0;

  logic [6:0] dec [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

  // model: e = clock edges since reset release
  int          e;
  logic [15:0] m_val, s_val;
  logic [3:0]  m_dp, s_dp;
  bit          m_pend;

  logic [6:0]  x_seg;
  logic        x_dp;
  logic [3:0]  x_en;
  logic        x_fd;
  bit          chk_en = 1'b0;

  task automatic cmp(input string nm, input logic [31:0] got,
                     input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s e=%0d got=%h want=%h", nm, e, got, want);
    end
  endtask

  function automatic bit lz_of(input int k);
    return LzBlank && (k != 0) && ((m_val >> (4*k)) == 16'h0)
           && ((m_dp >> k) == 4'h0);
  endfunction

  // Drive one cycle from a negedge; predict pins after the next posedge
  task automatic step(input bit ld, input logic [15:0] v,
                      input logic [3:0] d);
    int slot;
    bit lit;
    bit bnd;
    Load  = ld;
    Value = v;
    DpIn  = d;
    slot  = (e / DIV) % N;
    bnd   = (e % DIV == DIV - 1) && (slot == N - 1);
    lit   = DigitEn[slot] && !lz_of(slot);
    x_en  = lit ? ~(4'b0001 << slot) : 4'hF;
    x_seg = lit ? ~dec[m_val[4*slot +: 4]] : 7'h7F;
    x_dp  = lit ? ~m_dp[slot] : 1'b1;
    x_fd  = bnd;
    if (bnd && ld) begin
      m_val  = v;
      m_dp   = d;
      m_pend = 1'b0;
    end else if (bnd && m_pend) begin
      m_val  = s_val;
      m_dp   = s_dp;
      m_pend = 1'b0;
    end else if (ld) begin
      m_pend = 1'b1;
    end
    if (ld) begin
      s_val = v;
      s_dp  = d;
    end
    e++;
    chk_en = 1'b1;
    @(negedge Clk);
    Load = 1'b0;
  endtask

  task automatic run_to(input int target);
    while (e < target) step(1'b0, Value, DpIn);
  endtask

  // Assert reset off the clock edge; pins must go inactive at once
  task automatic do_reset(input int cycles);
    chk_en = 1'b0;
    #2 Reset_n = 1'b0;
    #1;
    cmp("rst_en", en_out, 4'hF);
    cmp("rst_seg", out7, 7'h7F);
    cmp("rst_dp", dp_out, 1'b1);
    cmp("rst_fd", frame_done, 1'b0);
    repeat (cycles) @(negedge Clk);
    Reset_n = 1'b1;
    e      = 0;
    m_val  = '0;
    m_dp   = '0;
    s_val  = '0;
    s_dp   = '0;
    m_pend = 1'b0;
  endtask

  // Compare every meaningful cycle against the model
  always @(posedge Clk) begin
    #1;
    if (chk_en) begin
      cmp("en_out", en_out, x_en);
      cmp("out7", out7, x_seg);
      cmp("dp_out", dp_out, x_dp);
      cmp("frame_done", frame_done, x_fd);
    end
  end

  initial begin
    do_reset(3);

    step(1'b0, 16'h0000, 4'h0);
    cmp("first_en", en_out, 4'b1110);
    cmp("first_seg", out7, 7'b0000001);
    run_to(5);
    cmp("slot1_en", en_out, 4'b1101);

    step(1'b1, 16'h12AF, 4'h0);
    run_to(15);
    cmp("hold_seg", out7, 7'b0000001);
    cmp("hold_en", en_out, 4'b0111);
    step(1'b0, Value, DpIn);
    cmp("fd_pulse", frame_done, 1'b1);
    step(1'b0, Value, DpIn);
    cmp("new_d0_seg", out7, 7'b0111000);
    cmp("new_d0_en", en_out, 4'b1110);
    run_to(29);
    cmp("new_d3_en", en_out, 4'b0111);
    cmp("new_d3_seg", out7, 7'b1001111);

    run_to(33);
    step(1'b1, 16'h1234, 4'h0);
    run_to(40);
    step(1'b1, 16'h5678, 4'h0);
    run_to(49);
    cmp("last_load_seg", out7, 7'b0000000);

    run_to(63);
    step(1'b1, 16'h9ABC, 4'b0001);
    step(1'b0, Value, DpIn);
    cmp("bnd_load_seg", out7, 7'b0110001);
    cmp("bnd_load_dp", dp_out, 1'b0);

    LzBlank = 1'b1;
    step(1'b1, 16'h0050, 4'h0);
    run_to(97);
    cmp("lz_d0_en", en_out, 4'b1110);
    run_to(109);
    cmp("lz_d3_en", en_out, 4'hF);
    cmp("lz_d3_seg", out7, 7'h7F);
    step(1'b1, 16'h0000, 4'h0);
    run_to(128);
    step(1'b1, 16'h0000, 4'b0100);
    run_to(160);
    LzBlank = 1'b0;

    DigitEn = 4'b1011;
    step(1'b1, 16'hBEEF, 4'b1010);
    run_to(200);
    DigitEn = 4'hF;

    repeat (1500) begin
      DigitEn = ($urandom % 4 == 0) ? 4'($urandom) : 4'hF;
      LzBlank = 1'($urandom);
      if ($urandom % 3 == 0)
        step(($urandom % 6) == 0, {12'h0, 4'($urandom)}, 4'h0);
      else
        step(($urandom % 6) == 0, 16'($urandom), 4'($urandom));
    end

    run_to(e + 7 - ((e + 7) % 16) + 6);
    do_reset(2);
    DigitEn = 4'hF;
    LzBlank = 1'b0;
    step(1'b0, 16'hFFFF, 4'hF);
    cmp("post_rst_en", en_out, 4'b1110);
    cmp("post_rst_seg", out7, 7'b0000001);
    repeat (400) begin
      DigitEn = ($urandom % 4 == 0) ? 4'($urandom) : 4'hF;
      LzBlank = 1'($urandom);
      step(($urandom % 5) == 0, 16'($urandom), 4'($urandom));
    end

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
